// File: rtl/lsb_queue_if.sv
// Memory-side request/response bus of the load/store queue.
// The queue drives the master side; the memory system is the slave.
interface lsb_queue_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store queue with CDB operand snooping, commit-gated stores and flush recovery.
// Optional macro LSB_PERF_EN adds retired-load/store and full-cycle counters.
module lsb_queue #(
  parameter int          DEPTH   = 16,
  parameter int          ROB_W   = 4,
  parameter int          NUM_CDB = 2,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  input  logic                     disp_store,
  input  logic [1:0]               disp_size,
  input  logic                     disp_unsigned,
  input  logic [31:0]              disp_imm,
  input  logic [ROB_W-1:0]         disp_rob,
  input  logic                     disp_j_rdy,
  input  logic                     disp_k_rdy,
  input  logic [31:0]              disp_j,
  input  logic [31:0]              disp_k,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  input  logic                     commit_valid,
  input  logic [ROB_W-1:0]         commit_rob,
  input  logic                     rob_head_valid,
  input  logic [ROB_W-1:0]         rob_head,
  lsb_queue_if.master              mem,
  output logic                     full,
  output logic                     ld_valid,
  output logic [ROB_W-1:0]         ld_rob,
  output logic [31:0]              ld_value
`ifdef LSB_PERF_EN
  ,
  output logic [31:0]              perf_loads,
  output logic [31:0]              perf_stores,
  output logic [31:0]              perf_full_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d, commitCnt;
  logic               full_q;

  logic [DEPTH-1:0]   busy_q, committed_q, store_q, unsigned_q, jRdy_q, kRdy_q;
  logic [1:0]         size_q  [DEPTH];
  logic [31:0]        imm_q   [DEPTH];
  logic [31:0]        jVal_q  [DEPTH];
  logic [31:0]        kVal_q  [DEPTH];
  logic [ROB_W-1:0]   rob_q   [DEPTH];

  logic               memReq_q, memWe_q;
  logic [31:0]        memAddr_q, memWdata_q;
  logic [1:0]         memSize_q;
  logic               ldValid_q;
  logic [ROB_W-1:0]   ldRob_q;
  logic [31:0]        ldValue_q;

  logic [DEPTH-1:0]   jHit, kHit;
  logic [31:0]        jCdb [DEPTH];
  logic [31:0]        kCdb [DEPTH];
  logic               dJHit, dKHit;
  logic [31:0]        dJCdb, dKCdb;
  logic [32:0]        lk;

  logic [31:0]        headAddr, loadExt;
  logic               headLoadOk, headStoreOk, retire, retireStore, dispAccept;

  // Channels are scanned high to low so the lowest matching index is the one kept.
  function automatic logic [32:0] cdbLookup(input logic [ROB_W-1:0] tag);
    logic [32:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == tag)) begin
        res = {1'b1, cdb_value[c*32 +: 32]};
      end
    end
    return res;
  endfunction

  always_comb begin
    lk = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk      = cdbLookup(jVal_q[i][ROB_W-1:0]);
      jHit[i] = lk[32];
      jCdb[i] = lk[31:0];
      lk      = cdbLookup(kVal_q[i][ROB_W-1:0]);
      kHit[i] = lk[32];
      kCdb[i] = lk[31:0];
    end
    lk    = cdbLookup(disp_j[ROB_W-1:0]);
    dJHit = lk[32];
    dJCdb = lk[31:0];
    lk    = cdbLookup(disp_k[ROB_W-1:0]);
    dKHit = lk[32];
    dKCdb = lk[31:0];
  end

  always_comb begin
    commitCnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && committed_q[i]) commitCnt = commitCnt + CNT_W'(1);
    end

    headAddr    = jVal_q[head_q] + imm_q[head_q];
    headLoadOk  = busy_q[head_q] && !store_q[head_q] && jRdy_q[head_q] &&
                  ((headAddr < IO_BASE) || (rob_head_valid && (rob_head == rob_q[head_q])));
    headStoreOk = busy_q[head_q] && store_q[head_q] && committed_q[head_q] &&
                  jRdy_q[head_q] && kRdy_q[head_q];
    retire      = (state_q == S_BUSY) && mem.mem_done;
    retireStore = retire && store_q[head_q];
    dispAccept  = disp_valid && !full_q && !flush;

    // Committed stores sit contiguously at head, so a flush keeps exactly that run.
    if (flush) begin
      head_d  = head_q + PTR_W'(retireStore);
      tail_d  = head_q + commitCnt[PTR_W-1:0];
      count_d = commitCnt - CNT_W'(retireStore);
    end else begin
      head_d  = head_q + PTR_W'(retire);
      tail_d  = tail_q + PTR_W'(dispAccept);
      count_d = count_q + CNT_W'(dispAccept) - CNT_W'(retire);
    end
  end

  always_comb begin
    loadExt = mem.mem_rdata;
    case (size_q[head_q])
      2'd0:    loadExt = unsigned_q[head_q] ? {24'b0, mem.mem_rdata[7:0]}
                                            : {{24{mem.mem_rdata[7]}}, mem.mem_rdata[7:0]};
      2'd1:    loadExt = unsigned_q[head_q] ? {16'b0, mem.mem_rdata[15:0]}
                                            : {{16{mem.mem_rdata[15]}}, mem.mem_rdata[15:0]};
      default: loadExt = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      busy_q      <= '0;
      committed_q <= '0;
      store_q     <= '0;
      unsigned_q  <= '0;
      jRdy_q      <= '0;
      kRdy_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        size_q[i] <= '0;
        imm_q[i]  <= '0;
        jVal_q[i] <= '0;
        kVal_q[i] <= '0;
        rob_q[i]  <= '0;
      end
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memSize_q  <= '0;
      memWdata_q <= '0;
      ldValid_q  <= 1'b0;
      ldRob_q    <= '0;
      ldValue_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      full_q    <= (count_d == CNT_W'(DEPTH));
      ldValid_q <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !jRdy_q[i] && jHit[i]) begin
          jRdy_q[i] <= 1'b1;
          jVal_q[i] <= jCdb[i];
        end
        if (busy_q[i] && !kRdy_q[i] && kHit[i]) begin
          kRdy_q[i] <= 1'b1;
          kVal_q[i] <= kCdb[i];
        end
        if (!flush && commit_valid && busy_q[i] && store_q[i] && (rob_q[i] == commit_rob)) begin
          committed_q[i] <= 1'b1;
        end
        if (flush && !committed_q[i]) busy_q[i] <= 1'b0;
      end

      if (retire) begin
        busy_q[head_q]      <= 1'b0;
        committed_q[head_q] <= 1'b0;
      end

      if (dispAccept) begin
        busy_q[tail_q]      <= 1'b1;
        committed_q[tail_q] <= 1'b0;
        store_q[tail_q]     <= disp_store;
        unsigned_q[tail_q]  <= disp_unsigned;
        size_q[tail_q]      <= disp_size;
        imm_q[tail_q]       <= disp_imm;
        rob_q[tail_q]       <= disp_rob;
        jRdy_q[tail_q]      <= disp_j_rdy || dJHit;
        jVal_q[tail_q]      <= disp_j_rdy ? disp_j : (dJHit ? dJCdb : disp_j);
        kRdy_q[tail_q]      <= disp_k_rdy || dKHit;
        kVal_q[tail_q]      <= disp_k_rdy ? disp_k : (dKHit ? dKCdb : disp_k);
      end

      // Request fields are captured once at issue and held until mem_done.
      case (state_q)
        S_IDLE: begin
          if (!flush && (headLoadOk || headStoreOk)) begin
            memReq_q   <= 1'b1;
            memWe_q    <= store_q[head_q];
            memAddr_q  <= headAddr;
            memSize_q  <= size_q[head_q];
            memWdata_q <= kVal_q[head_q];
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem.mem_done) begin
            memReq_q <= 1'b0;
            state_q  <= S_IDLE;
            if (!store_q[head_q] && !flush) begin
              ldValid_q <= 1'b1;
              ldRob_q   <= rob_q[head_q];
              ldValue_q <= loadExt;
            end
          end else if (flush && !store_q[head_q]) begin
            memReq_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = memReq_q;
  assign mem.mem_we    = memWe_q;
  assign mem.mem_addr  = memAddr_q;
  assign mem.mem_size  = memSize_q;
  assign mem.mem_wdata = memWdata_q;
  assign full          = full_q;
  assign ld_valid      = ldValid_q;
  assign ld_rob        = ldRob_q;
  assign ld_value      = ldValue_q;

`ifdef LSB_PERF_EN
  logic [31:0] perfLoads_q, perfStores_q, perfFull_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfLoads_q  <= '0;
      perfStores_q <= '0;
      perfFull_q   <= '0;
    end else begin
      if (retire && !store_q[head_q] && !flush) perfLoads_q <= perfLoads_q + 32'd1;
      if (retireStore) perfStores_q <= perfStores_q + 32'd1;
      if (full_q) perfFull_q <= perfFull_q + 32'd1;
    end
  end

  assign perf_loads       = perfLoads_q;
  assign perf_stores      = perfStores_q;
  assign perf_full_cycles = perfFull_q;
`endif

endmodule

// File: tb/tb_lsb_queue.sv
// Directed self-checking bench for lsb_queue (default parameters, perf counters disabled).
module tb_lsb_queue;

  logic        clk, rst_n, flush;
  logic        disp_valid, disp_store, disp_unsigned, disp_j_rdy, disp_k_rdy;
  logic [1:0]  disp_size;
  logic [31:0] disp_imm, disp_j, disp_k;
  logic [3:0]  disp_rob;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        commit_valid, rob_head_valid;
  logic [3:0]  commit_rob, rob_head;
  logic        full, ld_valid;
  logic [3:0]  ld_rob;
  logic [31:0] ld_value;

  int checks = 0;
  int errors = 0;

  lsb_queue_if memIf ();

  lsb_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_store     (disp_store),
    .disp_size      (disp_size),
    .disp_unsigned  (disp_unsigned),
    .disp_imm       (disp_imm),
    .disp_rob       (disp_rob),
    .disp_j_rdy     (disp_j_rdy),
    .disp_k_rdy     (disp_k_rdy),
    .disp_j         (disp_j),
    .disp_k         (disp_k),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .commit_valid   (commit_valid),
    .commit_rob     (commit_rob),
    .rob_head_valid (rob_head_valid),
    .rob_head       (rob_head),
    .mem            (memIf),
    .full           (full),
    .ld_valid       (ld_valid),
    .ld_rob         (ld_rob),
    .ld_value       (ld_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] imm,
                          input logic [3:0] rob, input logic jr, input logic [31:0] j,
                          input logic kr, input logic [31:0] k);
    disp_valid = 1'b1; disp_store = st; disp_size = sz; disp_unsigned = uns; disp_imm = imm;
    disp_rob = rob; disp_j_rdy = jr; disp_j = j; disp_k_rdy = kr; disp_k = k;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (memIf.mem_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; disp_valid = 0; disp_store = 0; disp_size = 0; disp_unsigned = 0;
    disp_imm = 0; disp_rob = 0; disp_j_rdy = 0; disp_k_rdy = 0; disp_j = 0; disp_k = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; commit_valid = 0; commit_rob = 0;
    rob_head_valid = 0; rob_head = 0; memIf.mem_done = 0; memIf.mem_rdata = 0;
    #12;
    checks++; if (memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b exp 0", memIf.mem_req); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b exp 0", full); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ldvalid: got %b exp 0", ld_valid); end
    checks++; if (memIf.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h exp 0", memIf.mem_addr); end
    checks++; if (ld_value !== 32'h0) begin errors++; $display("[TB] FAIL reset_ldvalue: got %h exp 0", ld_value); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_word();
    dispatch(1'b0, 2'd2, 1'b0, 32'h4, 4'd1, 1'b1, 32'h100, 1'b1, 32'h0);
    wait_req(10);
    checks++; if (memIf.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL lw_req: got %b exp 1", memIf.mem_req); end
    checks++; if (memIf.mem_addr !== 32'h104) begin errors++; $display("[TB] FAIL lw_addr: got %h exp %h", memIf.mem_addr, 32'h104); end
    checks++; if (memIf.mem_size !== 2'd2) begin errors++; $display("[TB] FAIL lw_size: got %0d exp 2", memIf.mem_size); end
    checks++; if (memIf.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL lw_we: got %b exp 0", memIf.mem_we); end
    tick(); tick();
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h104) begin errors++; $display("[TB] FAIL lw_hold: req %b addr %h exp 1 %h", memIf.mem_req, memIf.mem_addr, 32'h104); end
    memIf.mem_done = 1'b1; memIf.mem_rdata = 32'hDEADBEEF;
    tick();
    memIf.mem_done = 1'b0;
    checks++; if (ld_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_ldvalid: got %b exp 1", ld_valid); end
    checks++; if (ld_value !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_value: got %h exp %h", ld_value, 32'hDEADBEEF); end
    checks++; if (ld_rob !== 4'd1) begin errors++; $display("[TB] FAIL lw_rob: got %0d exp 1", ld_rob); end
    checks++; if (memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_req_gap: got %b exp 0", memIf.mem_req); end
    tick();
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_pulse: got %b exp 0", ld_valid); end
  endtask

  task automatic test_load_extend();
    logic [1:0]  sz  [3] = '{2'd0, 2'd0, 2'd1};
    logic        uns [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] rd  [3] = '{32'h00000080, 32'h00000080, 32'h1234F00F};
    logic [31:0] exv [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF00F};
    for (int i = 0; i < 3; i++) begin
      dispatch(1'b0, sz[i], uns[i], 32'h0, 4'(i + 2), 1'b1, 32'h200, 1'b1, 32'h0);
      wait_req(10);
      checks++; if (memIf.mem_size !== sz[i]) begin errors++; $display("[TB] FAIL ext_size%0d: got %0d exp %0d", i, memIf.mem_size, sz[i]); end
      memIf.mem_done = 1'b1; memIf.mem_rdata = rd[i];
      tick();
      memIf.mem_done = 1'b0;
      checks++; if (ld_valid !== 1'b1 || ld_value !== exv[i]) begin errors++; $display("[TB] FAIL ext_value%0d: valid %b value %h exp 1 %h", i, ld_valid, ld_value, exv[i]); end
      tick();
    end
  endtask

  task automatic test_dispatch_capture();
    cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd9}; cdb_value = {32'h00000999, 32'h00000300};
    dispatch(1'b0, 2'd2, 1'b0, 32'h8, 4'd7, 1'b0, 32'd9, 1'b1, 32'h0);
    cdb_valid = 2'b00;
    wait_req(10);
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h308) begin errors++; $display("[TB] FAIL capture_addr: req %b addr %h exp 1 %h", memIf.mem_req, memIf.mem_addr, 32'h308); end
    memIf.mem_done = 1'b1; memIf.mem_rdata = 32'h0;
    tick();
    memIf.mem_done = 1'b0;
    checks++; if (ld_valid !== 1'b1 || ld_rob !== 4'd7) begin errors++; $display("[TB] FAIL capture_ld: valid %b rob %0d exp 1 7", ld_valid, ld_rob); end
    tick();
  endtask

  task automatic test_store_cdb_commit();
    dispatch(1'b1, 2'd2, 1'b0, 32'h10, 4'd6, 1'b0, 32'd7, 1'b0, 32'd8);
    cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd9}; cdb_value = {32'h00000400, 32'h00000111};
    tick();
    cdb_valid = 2'b11; cdb_tag = {4'd8, 4'd8}; cdb_value = {32'hBAD0BAD0, 32'hCAFEF00D};
    tick();
    cdb_valid = 2'b00;
    tick(); tick();
    checks++; if (memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL st_early: got %b exp 0", memIf.mem_req); end
    commit_valid = 1'b1; commit_rob = 4'd6;
    tick();
    commit_valid = 1'b0;
    wait_req(10);
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL st_req: req %b we %b exp 1 1", memIf.mem_req, memIf.mem_we); end
    checks++; if (memIf.mem_addr !== 32'h410) begin errors++; $display("[TB] FAIL st_addr: got %h exp %h", memIf.mem_addr, 32'h410); end
    checks++; if (memIf.mem_wdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL st_wdata: got %h exp %h", memIf.mem_wdata, 32'hCAFEF00D); end
    memIf.mem_done = 1'b1;
    tick();
    memIf.mem_done = 1'b0;
    checks++; if (ld_valid !== 1'b0 || memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL st_retire: ldvalid %b req %b exp 0 0", ld_valid, memIf.mem_req); end
    checks++; if (dut.count_q !== 5'd0) begin errors++; $display("[TB] FAIL st_count: got %0d exp 0", dut.count_q); end
  endtask

  task automatic test_io_load();
    rob_head_valid = 1'b1; rob_head = 4'd3;
    dispatch(1'b0, 2'd2, 1'b0, 32'h30000, 4'd5, 1'b1, 32'h0, 1'b1, 32'h0);
    tick(); tick(); tick();
    checks++; if (memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL io_early: got %b exp 0", memIf.mem_req); end
    rob_head = 4'd5;
    wait_req(10);
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h30000) begin errors++; $display("[TB] FAIL io_req: req %b addr %h exp 1 %h", memIf.mem_req, memIf.mem_addr, 32'h30000); end
    memIf.mem_done = 1'b1; memIf.mem_rdata = 32'h77;
    tick();
    memIf.mem_done = 1'b0; rob_head_valid = 1'b0;
    checks++; if (ld_valid !== 1'b1 || ld_value !== 32'h77) begin errors++; $display("[TB] FAIL io_ld: valid %b value %h exp 1 %h", ld_valid, ld_value, 32'h77); end
    tick();
  endtask

  task automatic test_full_wrap();
    logic [31:0] expAddr;
    dispatch(1'b0, 2'd2, 1'b0, 32'h0, 4'd0, 1'b1, 32'h1000, 1'b1, 32'h0);
    for (int i = 1; i <= 14; i++) dispatch(1'b0, 2'd2, 1'b0, 32'(4 * i), 4'(i), 1'b0, 32'd15, 1'b1, 32'h0);
    checks++; if (full !== 1'b0 || memIf.mem_addr !== 32'h1000) begin errors++; $display("[TB] FAIL fill15: full %b addr %h exp 0 %h", full, memIf.mem_addr, 32'h1000); end
    memIf.mem_done = 1'b1; memIf.mem_rdata = 32'hA5A50000;
    dispatch(1'b0, 2'd2, 1'b0, 32'd60, 4'd15, 1'b0, 32'd15, 1'b1, 32'h0);
    memIf.mem_done = 1'b0;
    checks++; if (dut.count_q !== 5'd15 || full !== 1'b0) begin errors++; $display("[TB] FAIL disp_retire: count %0d full %b exp 15 0", dut.count_q, full); end
    checks++; if (ld_valid !== 1'b1 || ld_value !== 32'hA5A50000) begin errors++; $display("[TB] FAIL disp_retire_ld: valid %b value %h exp 1 %h", ld_valid, ld_value, 32'hA5A50000); end
    dispatch(1'b0, 2'd2, 1'b0, 32'd64, 4'd0, 1'b0, 32'd15, 1'b1, 32'h0);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_high: got %b exp 1", full); end
    dispatch(1'b0, 2'd2, 1'b0, 32'h999, 4'd1, 1'b1, 32'h0, 1'b1, 32'h0);
    checks++; if (dut.count_q !== 5'd16 || full !== 1'b1) begin errors++; $display("[TB] FAIL full_ignore: count %0d full %b exp 16 1", dut.count_q, full); end
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd15}; cdb_value = {32'h0, 32'h00002000};
    tick();
    cdb_valid = 2'b00;
    for (int i = 1; i <= 48; i++) begin
      if (i > 16) dispatch(1'b0, 2'd2, 1'b0, 32'(4 * i), 4'(i), 1'b1, 32'h3000, 1'b1, 32'h0);
      expAddr = ((i > 16) ? 32'h3000 : 32'h2000) + 32'(4 * i);
      wait_req(10);
      checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== expAddr) begin errors++; $display("[TB] FAIL wrap_addr%0d: req %b addr %h exp 1 %h", i, memIf.mem_req, memIf.mem_addr, expAddr); end
      memIf.mem_done = 1'b1; memIf.mem_rdata = expAddr ^ 32'h5A5A5A5A;
      tick();
      memIf.mem_done = 1'b0;
      checks++; if (ld_valid !== 1'b1 || ld_rob !== 4'(i) || ld_value !== (expAddr ^ 32'h5A5A5A5A)) begin errors++; $display("[TB] FAIL wrap_ld%0d: valid %b rob %0d value %h exp 1 %0d %h", i, ld_valid, ld_rob, ld_value, i % 16, expAddr ^ 32'h5A5A5A5A); end
    end
    checks++; if (dut.count_q !== 5'd0 || full !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty: count %0d full %b exp 0 0", dut.count_q, full); end
    tick();
  endtask

  task automatic test_flush();
    dispatch(1'b1, 2'd2, 1'b0, 32'h4, 4'd1, 1'b1, 32'h500, 1'b1, 32'h11111111);
    dispatch(1'b1, 2'd2, 1'b0, 32'h8, 4'd2, 1'b1, 32'h600, 1'b1, 32'h22222222);
    for (int i = 3; i <= 5; i++) dispatch(1'b0, 2'd2, 1'b0, 32'h0, 4'(i), 1'b1, 32'h700, 1'b1, 32'h0);
    checks++; if (memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fl_precommit: got %b exp 0", memIf.mem_req); end
    commit_valid = 1'b1; commit_rob = 4'd1;
    tick();
    commit_rob = 4'd2;
    tick();
    commit_valid = 1'b0;
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h504 || memIf.mem_wdata !== 32'h11111111) begin errors++; $display("[TB] FAIL fl_st1: req %b addr %h data %h exp 1 %h %h", memIf.mem_req, memIf.mem_addr, memIf.mem_wdata, 32'h504, 32'h11111111); end
    flush = 1'b1; memIf.mem_done = 1'b1;
    tick();
    flush = 1'b0; memIf.mem_done = 1'b0;
    checks++; if (dut.count_q !== 5'd1) begin errors++; $display("[TB] FAIL fl_count: got %0d exp 1", dut.count_q); end
    checks++; if (ld_valid !== 1'b0 || memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fl_after: ldvalid %b req %b exp 0 0", ld_valid, memIf.mem_req); end
    wait_req(10);
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h608 || memIf.mem_wdata !== 32'h22222222) begin errors++; $display("[TB] FAIL fl_st2: req %b addr %h data %h exp 1 %h %h", memIf.mem_req, memIf.mem_addr, memIf.mem_wdata, 32'h608, 32'h22222222); end
    memIf.mem_done = 1'b1;
    tick();
    memIf.mem_done = 1'b0;
    tick(); tick(); tick();
    checks++; if (memIf.mem_req !== 1'b0 || ld_valid !== 1'b0 || dut.count_q !== 5'd0) begin errors++; $display("[TB] FAIL fl_drained: req %b ldvalid %b count %0d exp 0 0 0", memIf.mem_req, ld_valid, dut.count_q); end
  endtask

  task automatic test_reset_midflight();
    dispatch(1'b0, 2'd2, 1'b0, 32'h0, 4'd3, 1'b1, 32'h800, 1'b1, 32'h0);
    wait_req(10);
    checks++; if (memIf.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_req: got %b exp 1", memIf.mem_req); end
    rst_n = 1'b0;
    #2;
    checks++; if (memIf.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_async: got %b exp 0", memIf.mem_req); end
    rst_n = 1'b1;
    tick();
    memIf.mem_done = 1'b1; memIf.mem_rdata = 32'h12345678;
    tick();
    memIf.mem_done = 1'b0;
    tick();
    checks++; if (ld_valid !== 1'b0 || memIf.mem_req !== 1'b0 || dut.count_q !== 5'd0) begin errors++; $display("[TB] FAIL mid_stale: ldvalid %b req %b count %0d exp 0 0 0", ld_valid, memIf.mem_req, dut.count_q); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_dispatch_capture();
    test_store_cdb_commit();
    test_io_load();
    test_full_wrap();
    test_flush();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsb_queue.md
LSB_QUEUE -- requirements
Module: lsb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of queue entries (power of 2, 2..64).
REQ-002 SHALL have parameter ROB_W, default 4, meaning ROB tag width.
REQ-003 SHALL have parameter NUM_CDB, default 2, meaning number of result broadcast channels snooped.
REQ-004 SHALL have parameter IO_BASE, default 32'h30000, meaning lowest memory-mapped I/O address.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  mispredict flush.
- disp_valid  in  1  dispatch new entry.
- disp_store  in  1  store (1) or load (0).
- disp_size  in  2  access size: 0 byte, 1 half, 2 word.
- disp_unsigned  in  1  zero-extend load.
- disp_imm  in  32  address offset.
- disp_rob  in  ROB_W  entry ROB tag.
- disp_j_rdy / disp_k_rdy  in  1 each  base / store-data operand is a value (1) or a tag (0).
- disp_j / disp_k  in  32 each  value, or tag in low ROB_W bits.
- cdb_valid  in  NUM_CDB  broadcast valid per channel.
- cdb_tag  in  NUM_CDB*ROB_W  broadcast tags, packed.
- cdb_value  in  NUM_CDB*32  broadcast values, packed.
- commit_valid  in  1  ROB commits a store.
- commit_rob  in  ROB_W  tag of committed store.
- rob_head_valid  in  1  ROB head valid.
- rob_head  in  ROB_W  ROB head tag.
- mem_req  out  1  memory request.
- mem_we  out  1  write.
- mem_addr  out  32  byte address.
- mem_size  out  2  access size.
- mem_wdata  out  32  store data.
- mem_done  in  1  one-cycle completion pulse.
- mem_rdata  in  32  raw load data, low-aligned.
- full  out  1  registered; no dispatch allowed next cycle.
- ld_valid  out  1  load result pulse.
- ld_rob  out  ROB_W  load tag.
- ld_value  out  32  extended load value.

Function
REQ-006 SHALL be an in-order circular queue with ROB_W-independent head/tail pointers wrapping modulo DEPTH, plus occupancy count of width log2(DEPTH)+1.
REQ-007 SHALL write a dispatch at tail; an operand whose tag matches any valid cdb channel in the same cycle SHALL capture that value (lowest channel index wins).
REQ-008 SHALL update every busy entry's waiting operand on a matching cdb broadcast, checking all NUM_CDB channels each cycle.
REQ-009 SHALL mark the busy entry whose tag equals commit_rob as committed; non-matching commit_rob SHALL be ignored.
REQ-010 SHALL issue a head load when base is ready and (addr < IO_BASE, or rob_head_valid and rob_head equals its tag); addr = base + imm, modulo 2^32.
REQ-011 SHALL issue a head store only when committed and both operands are ready.
REQ-012 SHALL hold mem_req and all mem_* fields stable from assertion until the cycle mem_done is seen; mem_req SHALL be low for at least the cycle after mem_done.
REQ-013 On mem_done for a load, SHALL retire head and pulse ld_valid for exactly one cycle, on the following cycle. ld_value SHALL be sign-extended for signed byte/half loads and zero-extended for unsigned ones.
REQ-014 On mem_done for a store, SHALL retire head with no ld_valid.
REQ-015 Same-cycle dispatch and retire SHALL leave count unchanged. full SHALL equal (next count == DEPTH). Dispatch while full SHALL be ignored.
REQ-016 On flush, SHALL drop all uncommitted entries, set tail = head + committed count, deassert mem_req unless a committed store is in flight, and suppress ld_valid. A store completing in the flush cycle SHALL still retire. A load completing in that cycle SHALL be discarded.
REQ-017 Committed stores SHALL always occupy a contiguous run starting at head.

Reset
REQ-018 On rst_n low, SHALL asynchronously clear count, head, tail, all busy and committed flags, mem_req, ld_valid and full. mem_we, mem_addr, mem_size, mem_wdata, ld_rob and ld_value SHALL reset to 0.
REQ-019 Reset mid-transaction SHALL abandon it, and a later stale mem_done SHALL be ignored while the queue is empty.

Configuration
REQ-020 With macro LSB_PERF_EN defined, SHALL add 32-bit wrapping output counters perf_loads, perf_stores and perf_full_cycles (retired loads, retired stores, cycles with full high), reset to 0. Without it, these ports and counters SHALL not exist.

Verification
REQ-021 Dispatch LW, base ready 0x100, imm 4 -> mem_addr 0x104, size 2. Then mem_done with rdata 0xDEADBEEF -> ld_valid one cycle later with value 0xDEADBEEF.
REQ-022 LB, rdata 0x80 -> ld_value 0xFFFFFF80. LBU, same rdata -> 0x00000080.
REQ-023 SW, tags pending, resolved via cdb channel 1, then commit -> mem_we=1 with resolved addr/data. No request occurs before commit.
REQ-024 Load to 0x30000, tag 5: no request while rob_head=3. Request when rob_head=5.
REQ-025 Fill DEPTH entries -> full high. Dispatch and retire in same cycle -> full and count unchanged. Pointers wrap correctly after 3*DEPTH operations.
REQ-026 2 committed stores + 3 loads, flush while store 1 completes -> store 1 retires, store 2 remains, count=1, no ld_valid.
